// File: rtl/s_mem_arbiter.sv
// S-array RAM arbiter for init/KSA/PRGA: one access per 3+RD_LAT cycles, ack 2+RD_LAT cycles after the IDLE grant; losers wait, no time-out.
// Fixed priority prga > ksa > init; define S_MEM_ARB_RR_EN for round-robin. An owner holding lock excludes all other requesters.
module s_mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [2:0]  lock,
    input  logic [2:0]  wren,
    input  logic [23:0] addr_in,
    input  logic [23:0] wdata_in,
    output logic [2:0]  ack,
    output logic [7:0]  rdata,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wren,
    input  logic [7:0]  mem_q
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic       lock_q, lock_d;
    logic       wr_q, wr_d;
    logic [2:0] ack_q, ack_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    logic [3:0] lock_x;
    logic       hold;
    logic [2:0] eligible;
    logic       grant;
    logic [1:0] winner;

    function automatic logic [7:0] lane(input logic [23:0] bus, input logic [1:0] idx);
        case (idx)
            2'd2:    lane = bus[23:16];
            2'd1:    lane = bus[15:8];
            default: lane = bus[7:0];
        endcase
    endfunction

    // owner_q is 3 after reset, so the lock vector is padded to make that index harmless
    assign lock_x = {1'b0, lock};
    assign hold   = lock_q && lock_x[owner_q];

    always_comb begin
        eligible = req;
        if (hold) begin
            eligible = req & (3'b001 << owner_q);
        end
    end

`ifdef S_MEM_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    // descending scan so the candidate nearest ptr+1 is the last assignment to stick
    always_comb begin
        grant  = 1'b0;
        winner = 2'd0;
        cand   = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(ptr_q) + k) % 3);
            if (eligible[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
        ptr_d = (state_q == S_IDLE && grant) ? winner : ptr_q;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) ptr_q <= 2'd2;
        else          ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant  = |eligible;
        winner = eligible[2] ? 2'd2 : (eligible[1] ? 2'd1 : 2'd0);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        wr_d    = wr_q;
        ack_d   = 3'b000;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                lock_d = hold;
                if (grant) begin
                    state_d = S_ISSUE;
                    owner_d = winner;
                    lock_d  = lock[winner];
                    wr_d    = wren[winner];
                    addr_d  = lane(addr_in, winner);
                    data_d  = lane(wdata_in, winner);
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = 2'd0;
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                    ack_d   = 3'b001 << owner_q;
                    if (!wr_q) rdata_d = mem_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            owner_q <= 2'd3;
            lock_q  <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= 3'b000;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_wren = (state_q == S_ISSUE) && wr_q;
endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: transaction-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_s_mem_arbiter;
    localparam int RD_LAT = 1;
    localparam int LAT    = 2 + RD_LAT;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    logic [2:0]  req = '0, lock = '0, wren = '0;
    logic [23:0] addr_in = '0, wdata_in = '0;
    logic [2:0]  ack;
    logic [7:0]  rdata, mem_addr, mem_data, mem_q;
    logic [1:0]  owner;
    logic        busy, mem_wren;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    s_mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req(req), .lock(lock), .wren(wren),
        .addr_in(addr_in), .wdata_in(wdata_in), .ack(ack), .rdata(rdata), .owner(owner),
        .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // RAM with RD_LAT-cycle registered read
    logic [7:0] ram [256];
    logic [7:0] q_pipe [3];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0, pre_dat = '0;
    always @(posedge CLOCK_50) begin
        if (pre_we)        ram[pre_addr] <= pre_dat;
        else if (mem_wren) ram[mem_addr] <= mem_data;
        q_pipe[0] <= ram[mem_addr];
        q_pipe[1] <= q_pipe[0];
        q_pipe[2] <= q_pipe[1];
    end
    assign mem_q = q_pipe[RD_LAT-1];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a grant at sample cycle c-1 occupies cycles c .. c+1+RD_LAT
    logic [7:0] ref_mem [256];
    int   cyc = 0, free_at = 0, t_iss = -100, t_resp = -100;
    int   ptr = 2, lk_own = 0;
    bit   lk = 1'b0, m_wr = 1'b0;
    logic [2:0] x_ack = '0;
    logic [7:0] x_rdata = '0, x_addr = '0, x_data = '0;
    logic [1:0] x_owner = 2'd3;
    logic       x_busy = 1'b0, x_wren = 1'b0;

    function automatic int pick(input logic [2:0] elig);
        int w = -1;
`ifdef S_MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++)
            if (w < 0 && elig[(ptr + k) % 3]) w = (ptr + k) % 3;
`else
        for (int i = 2; i >= 0; i--)
            if (w < 0 && elig[i]) w = i;
`endif
        return w;
    endfunction

    task automatic model_reset();
        free_at = 0; t_iss = -100; t_resp = -100; ptr = 2; lk = 1'b0; m_wr = 1'b0;
        x_ack = '0; x_rdata = '0; x_addr = '0; x_data = '0; x_owner = 2'd3; x_busy = 1'b0; x_wren = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] elig;
        int w;
        cyc++;
        if (cyc - 1 >= free_at) begin
            if (lk && !lock[lk_own]) lk = 1'b0;
            elig = lk ? (req & (3'b001 << lk_own)) : req;
            w = pick(elig);
            if (w >= 0) begin
                t_iss = cyc; t_resp = cyc + 1 + RD_LAT; free_at = cyc + 2 + RD_LAT;
                m_wr = wren[w]; x_owner = 2'(w);
                x_addr = addr_in[8*w +: 8]; x_data = wdata_in[8*w +: 8];
                lk = lock[w]; lk_own = w; ptr = w;
                if (m_wr) ref_mem[x_addr] = x_data;
            end
        end
        x_busy = (cyc >= t_iss) && (cyc <= t_resp);
        x_wren = (cyc == t_iss) && m_wr;
        x_ack  = (cyc == t_resp) ? (3'b001 << x_owner) : 3'b000;
        if (cyc == t_resp && !m_wr) x_rdata = ref_mem[x_addr];
    endtask

    initial forever begin
        @(posedge CLOCK_50 or negedge reset_n);
        if (!reset_n) model_reset();
        else          model_step();
    end

    bit chk_en = 1'b0;
    int ack_cnt [3] = '{0, 0, 0};
    int wren_pulses = 0;
    initial forever begin
        @(negedge CLOCK_50);
        for (int i = 0; i < 3; i++) if (ack[i]) ack_cnt[i]++;
        if (mem_wren) wren_pulses++;
        if (chk_en) begin
            cmp("cyc_ack", ack, x_ack);
            cmp("cyc_rdata", rdata, x_rdata);
            cmp("cyc_owner", owner, x_owner);
            cmp("cyc_busy", busy, x_busy);
            cmp("cyc_mem_wren", mem_wren, x_wren);
            cmp("cyc_mem_addr", mem_addr, x_addr);
            cmp("cyc_mem_data", mem_data, x_data);
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d; ref_mem[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Present a request in an IDLE cycle, return ack latency and rdata, end in the following IDLE cycle
    task automatic access(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input bit lk_b, output int lat, output logic [7:0] rd);
        req[r] = 1'b1; wren[r] = wr; addr_in[8*r +: 8] = a; wdata_in[8*r +: 8] = d; lock[r] = lk_b;
        lat = 0;
        do begin tick(); lat++; end while (ack[r] !== 1'b1 && lat < 30);
        cmp("access_ack_bound", lat < 30, 1);
        rd = rdata;
        req[r] = 1'b0;
        tick();
    endtask

    task automatic wait_ack(output int idx);
        int n = 0;
        idx = -1;
        do begin tick(); n++; end while (ack == 3'b000 && n < 30);
        cmp("wait_ack_bound", n < 30, 1);
        for (int i = 0; i < 3; i++) if (ack[i]) idx = i;
    endtask

    task automatic pulse_reset();
        @(negedge CLOCK_50); reset_n = 1'b0;
        @(negedge CLOCK_50); reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, n, base_p, base_k, base_w;
        logic [7:0] rd, rd_i, rd_j;
        int exp_held [6];
        int exp_drop [3];
`ifdef S_MEM_ARB_RR_EN
        exp_held = '{0, 1, 2, 0, 1, 2};
        exp_drop = '{0, 1, 2};
`else
        exp_held = '{2, 2, 2, 2, 2, 2};
        exp_drop = '{2, 1, 0};
`endif
        #1 reset_n = 1'b0;
        #2;
        cmp("reset_ack", ack, 3'b000);
        cmp("reset_owner", owner, 2'd3);
        cmp("reset_busy", busy, 1'b0);
        cmp("reset_rdata", rdata, 8'h00);
        cmp("reset_mem_addr", mem_addr, 8'h00);
        cmp("reset_mem_wren", mem_wren, 1'b0);
        chk_en = 1'b1;
        @(posedge CLOCK_50); @(negedge CLOCK_50); reset_n = 1'b1;
        tick();
        preload(8'h2A, 8'h5C);
        preload(8'h03, 8'h11);
        preload(8'h09, 8'h99);

        // read, no contention
        req[0] = 1'b1; wren[0] = 1'b0; addr_in[7:0] = 8'h2A;
        tick();
        cmp("t1_c1_busy", busy, 1'b1);
        cmp("t1_c1_owner", owner, 2'd0);
        cmp("t1_c1_mem_addr", mem_addr, 8'h2A);
        cmp("t1_c1_ack", ack, 3'b000);
        tick();
        cmp("t1_c2_busy", busy, 1'b1);
        cmp("t1_c2_ack", ack, 3'b000);
        tick();
        cmp("t1_c3_ack", ack, 3'b001);
        cmp("t1_c3_rdata", rdata, 8'h5C);
        cmp("t1_c3_busy", busy, 1'b1);
        req[0] = 1'b0;
        tick();
        cmp("t1_c4_busy", busy, 1'b0);
        cmp("t1_c4_ack", ack, 3'b000);

        // write then read
        base_w = wren_pulses;
        access(1, 1'b1, 8'h10, 8'hA7, 1'b0, lat, rd);
        cmp("t2_write_lat", lat, LAT);
        cmp("t2_write_rdata_unchanged", rd, 8'h5C);
        cmp("t2_wren_pulses", wren_pulses - base_w, 1);
        access(1, 1'b0, 8'h10, 8'h00, 1'b0, lat, rd);
        cmp("t2_read_lat", lat, LAT);
        cmp("t2_read_back", rd, 8'hA7);

        // contention, all requests held
        pulse_reset();
        addr_in = {8'h03, 8'h10, 8'h2A}; wdata_in = '0; wren = '0; lock = '0;
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            wait_ack(w0);
            cmp($sformatf("t3_held_grant%0d", g), w0, exp_held[g]);
        end
        req = '0;
        tick();
        // contention, each requester leaves after its ack
        req = 3'b111;
        for (int g = 0; g < 3; g++) begin
            wait_ack(w0);
            cmp($sformatf("t3_drop_grant%0d", g), w0, exp_drop[g]);
            if (w0 >= 0) req[w0] = 1'b0;
        end
        req = '0;
        tick();
`ifndef S_MEM_ARB_RR_EN
        req = 3'b111;
        wait_ack(w0);
        cmp("t3_regrant_first", w0, 2);
        req[2] = 1'b0;
        tick();
        req[2] = 1'b1;
        wait_ack(w0);
        cmp("t3_regrant_prga", w0, 2);
        req = '0;
        tick();
`endif

        // atomic swap under ksa lock with prga waiting
        base_p = ack_cnt[2];
        base_k = ack_cnt[1];
        access(1, 1'b0, 8'h03, 8'h00, 1'b1, lat, rd_i);
        req[2] = 1'b1; wren[2] = 1'b0; addr_in[23:16] = 8'h2A; lock[2] = 1'b1;
        access(1, 1'b0, 8'h09, 8'h00, 1'b1, lat, rd_j);
        access(1, 1'b1, 8'h03, rd_j, 1'b1, lat, rd);
        access(1, 1'b1, 8'h09, rd_i, 1'b1, lat, rd);
        cmp("t4_read_i", rd_i, 8'h11);
        cmp("t4_read_j", rd_j, 8'h99);
        cmp("t4_ksa_acks", ack_cnt[1] - base_k, 4);
        cmp("t4_prga_acks_while_locked", ack_cnt[2] - base_p, 0);
        repeat (3) begin
            tick();
            cmp("t4_locked_idle_busy", busy, 1'b0);
        end
        lock[1] = 1'b0;
        tick();
        cmp("t4_unlock_owner", owner, 2'd2);
        cmp("t4_unlock_busy", busy, 1'b1);
        wait_ack(w0);
        cmp("t4_prga_ack", w0, 2);
        req[2] = 1'b0; lock[2] = 1'b0;
        tick();
        access(0, 1'b0, 8'h03, 8'h00, 1'b0, lat, rd);
        cmp("t4_swapped_i", rd, 8'h99);

        // reset during WAIT of a prga read
        req[2] = 1'b1; wren[2] = 1'b0; addr_in[23:16] = 8'h03; wdata_in[23:16] = 8'hEE;
        tick();
        req[0] = 1'b1; wren[0] = 1'b0; addr_in[7:0] = 8'h2A;
        tick();
        cmp("t5_wait_busy", busy, 1'b1);
        base_p = ack_cnt[2];
        #2 reset_n = 1'b0;
        #1;
        cmp("t5_rst_ack", ack, 3'b000);
        cmp("t5_rst_owner", owner, 2'd3);
        cmp("t5_rst_busy", busy, 1'b0);
        cmp("t5_rst_rdata", rdata, 8'h00);
        cmp("t5_rst_mem_addr", mem_addr, 8'h00);
        cmp("t5_rst_mem_data", mem_data, 8'h00);
        cmp("t5_rst_mem_wren", mem_wren, 1'b0);
        req[2] = 1'b0;
        @(posedge CLOCK_50); @(negedge CLOCK_50); reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ack[0] !== 1'b1 && n < 30);
        cmp("t5_init_ack_cycle", n, LAT);
        cmp("t5_init_rdata", rdata, 8'h5C);
        req[0] = 1'b0;
        repeat (3) tick();
        cmp("t5_no_prga_ack", ack_cnt[2] - base_p, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
